// File: rtl/receiver_mpi.sv
// receiver_mpi: receiving end of the credit-based valid/yummy link.
// Captures 64-bit flits into a DEPTH-entry FIFO, presents the head flit on a
// valid/ready interface and returns one registered yummy_o credit per flit
// drained.
// Optional feature macro: METRO_MPI_RX_SEQ_CHECK_EN enables the incrementing
// sequence checker that drives seq_err_o; without it seq_err_o is tied low.
//
// Handshake: downstream transfer (pop) happens on a rising edge where
// valid_o && ready_i; valid_o does not depend on ready_i and data_o stays
// stable while valid_o is high and ready_i is low. On the link side valid_i
// is unconditional (no ready); flow control comes from the yummy credits.
module receiver_mpi #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             valid_i,
    input  logic [63:0]      data_i,
    output logic             yummy_o,
    output logic [63:0]      data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o,
    output logic             seq_err_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [63:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             yummy_q, yummy_d;
    logic             overflow_q, overflow_d;
    logic             full;
    logic             push;
    logic             pop;

    // A full FIFO can still take a flit when the head leaves in the same cycle.
    assign full    = (count_q == CNT_W'(DEPTH));
    assign valid_o = (count_q != '0);
    assign pop     = valid_o && ready_i;
    assign push    = valid_i && (!full || pop);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : 64'h0;

    assign yummy_o    = yummy_q;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

    // Next-state for pointers, occupancy, credit return and overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        yummy_d    = pop;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        // A flit arriving at a full FIFO with no pop is a sender protocol violation.
        if (valid_i && !push) begin
            overflow_d = 1'b1;
        end
    end

    // Control state registers; reset discards buffered flits and pending credit.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            yummy_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            yummy_q    <= yummy_d;
            overflow_q <= overflow_d;
        end
    end

    // Flit storage; contents are intentionally left unreset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

`ifdef METRO_MPI_RX_SEQ_CHECK_EN
    logic [63:0] exp_q, exp_d;
    logic        seq_err_q, seq_err_d;
    logic        seq_mismatch;

    assign seq_mismatch = push && (data_i != exp_q);

    // Expected value follows every accepted flit; after a match data_i + 1
    // equals exp_q + 1, so resynchronising after a mismatch is the same rule.
    always_comb begin
        exp_d     = exp_q;
        seq_err_d = seq_err_q;
        if (push) begin
            exp_d = data_i + 64'd1;
        end
        if (seq_mismatch) begin
            seq_err_d = 1'b1;
        end
    end

    // Sequence checker registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            exp_q     <= 64'hcafe_cafe_cafe_cafe;
            seq_err_q <= 1'b0;
        end else begin
            exp_q     <= exp_d;
            seq_err_q <= seq_err_d;
        end
    end

    // Report each out-of-sequence flit as it is accepted.
    always @(posedge clk_i) begin
        if (rstn_i && seq_mismatch) begin
            $display("receiver_mpi: sequence error, received %h expected %h", data_i, exp_q);
        end
    end

    assign seq_err_o = seq_err_q;
`else
    assign seq_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_receiver_mpi.sv
// Testbench for receiver_mpi: directed scenarios plus a randomized stream
// checked against a queue-based reference model.
module tb_receiver_mpi;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk_i;
    logic             rstn_i;
    logic             valid_i;
    logic [63:0]      data_i;
    logic             yummy_o;
    logic [63:0]      data_o;
    logic             valid_o;
    logic             ready_i;
    logic [CNT_W-1:0] count_o;
    logic             overflow_o;
    logic             seq_err_o;

    int checks;
    int failures;

    // Reference model state
    logic [63:0] mdl_q[$];
    logic        mdl_yummy;
    logic        mdl_ovf;
    logic        mdl_seq_err;
    logic [63:0] mdl_exp;

    receiver_mpi #(.DEPTH(DEPTH)) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .yummy_o    (yummy_o),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .count_o    (count_o),
        .overflow_o (overflow_o),
        .seq_err_o  (seq_err_o)
    );

    // Clock
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic model_clear();
        mdl_q.delete();
        mdl_yummy   = 1'b0;
        mdl_ovf     = 1'b0;
        mdl_seq_err = 1'b0;
        mdl_exp     = 64'hcafe_cafe_cafe_cafe;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rstn_i  = 1'b0;
        valid_i = 1'b0;
        data_i  = 64'h0;
        ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        model_clear();
    endtask

    // Apply inputs from a negedge, advance the model across the posedge,
    // return at the next negedge with outputs settled.
    task automatic cycle(input logic v, input logic [63:0] d, input logic r);
        logic pop;
        logic push;
        valid_i = v;
        data_i  = d;
        ready_i = r;
        @(posedge clk_i);
        pop  = (mdl_q.size() != 0) && r;
        push = v && ((mdl_q.size() != DEPTH) || pop);
        if (pop) void'(mdl_q.pop_front());
        if (push) begin
            mdl_q.push_back(d);
`ifdef METRO_MPI_RX_SEQ_CHECK_EN
            if (d != mdl_exp) mdl_seq_err = 1'b1;
            mdl_exp = d + 64'd1;
`endif
        end
        if (v && !push) mdl_ovf = 1'b1;
        mdl_yummy = pop;
        @(negedge clk_i);
        valid_i = 1'b0;
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        checks++;
        if (data_o !== 64'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", data_o); end
        checks++;
        if (count_o !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        checks++;
        if ({yummy_o, overflow_o, seq_err_o} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got=%b exp=000", {yummy_o, overflow_o, seq_err_o});
        end
    endtask

    task automatic test_single_flit();
        do_reset();
        cycle(1'b1, 64'hcafe_cafe_cafe_cafe, 1'b1);
        checks++;
        if (valid_o !== 1'b1 || data_o !== 64'hcafe_cafe_cafe_cafe) begin
            failures++; $display("FAIL single_head got=%b/%h exp=1/cafecafecafecafe", valid_o, data_o);
        end
        checks++;
        if (count_o !== CNT_W'(1) || yummy_o !== 1'b0) begin
            failures++; $display("FAIL single_count got=%0d/%b exp=1/0", count_o, yummy_o);
        end
        ready_i = 1'b1;
        cycle(1'b0, 64'h0, 1'b1);
        checks++;
        if (yummy_o !== 1'b1 || valid_o !== 1'b0 || count_o !== '0) begin
            failures++; $display("FAIL single_pop yummy/valid/count got=%b/%b/%0d exp=1/0/0", yummy_o, valid_o, count_o);
        end
        cycle(1'b0, 64'h0, 1'b1);
        checks++;
        if (yummy_o !== 1'b0) begin failures++; $display("FAIL single_yummy_once got=%b exp=0", yummy_o); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_flit [7];
        do_reset();
        for (int i = 0; i < 7; i++) begin
            exp_flit[i] = 64'hcafe_cafe_cafe_cafe + 64'(i);
            cycle(1'b1, exp_flit[i], 1'b0);
            checks++;
            if (yummy_o !== 1'b0) begin failures++; $display("FAIL fill_yummy[%0d] got=%b exp=0", i, yummy_o); end
        end
        checks++;
        if (count_o !== CNT_W'(7) || overflow_o !== 1'b0) begin
            failures++; $display("FAIL fill_state count/ovf got=%0d/%b exp=7/0", count_o, overflow_o);
        end
        for (int i = 0; i < 7; i++) begin
            ready_i = 1'b1;
            #1;
            checks++;
            if (valid_o !== 1'b1 || data_o !== exp_flit[i]) begin
                failures++; $display("FAIL drain_data[%0d] got=%b/%h exp=1/%h", i, valid_o, data_o, exp_flit[i]);
            end
            cycle(1'b0, 64'h0, 1'b1);
            checks++;
            if (yummy_o !== 1'b1) begin failures++; $display("FAIL drain_yummy[%0d] got=%b exp=1", i, yummy_o); end
        end
        checks++;
        if (count_o !== '0 || valid_o !== 1'b0) begin
            failures++; $display("FAIL drain_empty count/valid got=%0d/%b exp=0/0", count_o, valid_o);
        end
        // Sustained stream: one flit in and one out every cycle.
        cycle(1'b1, 64'h1000, 1'b1);
        for (int i = 1; i < 10; i++) begin
            cycle(1'b1, 64'h1000 + 64'(i), 1'b1);
            checks++;
            if (count_o !== CNT_W'(1) || data_o !== 64'h1000 + 64'(i) || yummy_o !== 1'b1) begin
                failures++; $display("FAIL stream[%0d] count/data/yummy got=%0d/%h/%b", i, count_o, data_o, yummy_o);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 64'h200 + 64'(i), 1'b0);
        checks++;
        if (count_o !== CNT_W'(8) || overflow_o !== 1'b0) begin
            failures++; $display("FAIL ovf_full count/ovf got=%0d/%b exp=8/0", count_o, overflow_o);
        end
        cycle(1'b1, 64'hdead, 1'b0);
        checks++;
        if (count_o !== CNT_W'(8) || overflow_o !== 1'b1 || data_o !== 64'h200) begin
            failures++; $display("FAIL ovf_drop count/ovf/data got=%0d/%b/%h exp=8/1/200", count_o, overflow_o, data_o);
        end
        cycle(1'b1, 64'h300, 1'b1);
        checks++;
        if (count_o !== CNT_W'(8) || data_o !== 64'h201 || yummy_o !== 1'b1 || overflow_o !== 1'b1) begin
            failures++; $display("FAIL ovf_pushpop count/data/yummy/ovf got=%0d/%h/%b/%b exp=8/201/1/1", count_o, data_o, yummy_o, overflow_o);
        end
        // The flit accepted while full must sit at the tail, the dropped one nowhere.
        for (int i = 0; i < 8; i++) begin
            ready_i = 1'b1;
            #1;
            checks++;
            if (data_o !== ((i < 7) ? 64'h201 + 64'(i) : 64'h300)) begin
                failures++; $display("FAIL ovf_order[%0d] got=%h", i, data_o);
            end
            cycle(1'b0, 64'h0, 1'b1);
        end
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 64'hcafe_cafe_cafe_cafe + 64'(i), 1'b0);
        checks++;
        if (count_o !== CNT_W'(5)) begin failures++; $display("FAIL mid_count got=%0d exp=5", count_o); end
        ready_i = 1'b1;
        cycle(1'b0, 64'h0, 1'b1);
        ready_i = 1'b1;
        #2;
        rstn_i = 1'b0;
        #1;
        checks++;
        if ({valid_o, yummy_o, overflow_o, seq_err_o} !== 4'b0000 || count_o !== '0 || data_o !== 64'h0) begin
            failures++; $display("FAIL mid_reset valid/yummy/ovf/seq/count got=%b%b%b%b/%0d exp=0000/0", valid_o, yummy_o, overflow_o, seq_err_o, count_o);
        end
        @(negedge clk_i);
        rstn_i = 1'b1;
        ready_i = 1'b0;
        model_clear();
        cycle(1'b0, 64'h0, 1'b1);
        checks++;
        if (yummy_o !== 1'b0 || count_o !== '0) begin
            failures++; $display("FAIL mid_after yummy/count got=%b/%0d exp=0/0", yummy_o, count_o);
        end
    endtask

    task automatic test_random_stream();
        logic        v;
        logic        r;
        logic [63:0] d;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 99) < 70);
            r = ($urandom_range(0, 99) < ((i < 200) ? 40 : 80));
            d = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : mdl_exp;
            cycle(v, d, r);
            checks++;
            if (count_o !== CNT_W'(mdl_q.size()) || valid_o !== (mdl_q.size() != 0)) begin
                failures++; $display("FAIL rand_count[%0d] got=%0d/%b exp=%0d", i, count_o, valid_o, mdl_q.size());
            end
            checks++;
            if (data_o !== ((mdl_q.size() != 0) ? mdl_q[0] : 64'h0)) begin
                failures++; $display("FAIL rand_data[%0d] got=%h", i, data_o);
            end
            checks++;
            if (yummy_o !== mdl_yummy || overflow_o !== mdl_ovf || seq_err_o !== mdl_seq_err) begin
                failures++; $display("FAIL rand_flags[%0d] got=%b%b%b exp=%b%b%b", i, yummy_o, overflow_o, seq_err_o, mdl_yummy, mdl_ovf, mdl_seq_err);
            end
        end
    endtask

`ifdef METRO_MPI_RX_SEQ_CHECK_EN
    task automatic test_seq_check();
        do_reset();
        cycle(1'b1, 64'hcafe_cafe_cafe_cafe, 1'b1);
        checks++;
        if (seq_err_o !== 1'b0) begin failures++; $display("FAIL seq_first got=%b exp=0", seq_err_o); end
        cycle(1'b1, 64'hcafe_cafe_cafe_cb00, 1'b1);
        checks++;
        if (seq_err_o !== 1'b1) begin failures++; $display("FAIL seq_err got=%b exp=1", seq_err_o); end
        cycle(1'b1, 64'hcafe_cafe_cafe_cb01, 1'b1);
        checks++;
        if (seq_err_o !== 1'b1) begin failures++; $display("FAIL seq_sticky got=%b exp=1", seq_err_o); end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        rstn_i   = 1'b0;
        valid_i  = 1'b0;
        data_i   = 64'h0;
        ready_i  = 1'b0;
        model_clear();
        test_reset();
        test_single_flit();
        test_back_to_back();
        test_overflow();
        test_reset_mid_stream();
        test_random_stream();
`ifdef METRO_MPI_RX_SEQ_CHECK_EN
        test_seq_check();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
